// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO mul/div controller: op one-hot indices,
// FSM state encoding and parameter defaults.
package muldiv_pkg;

  localparam int OP_MULT  = 0;
  localparam int OP_MULTU = 1;
  localparam int OP_DIV   = 2;
  localparam int OP_DIVU  = 3;
  localparam int OP_MTHI  = 4;
  localparam int OP_MTLO  = 5;

  localparam int MUL_LAT_DEF     = 2;
  localparam int DIV_TIMEOUT_DEF = 40;
  // Shared MUL/DIV cycle counter width; covers DIV_TIMEOUT up to 255.
  localparam int CNT_W           = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MUL   = 2'd1,
    ST_DIV   = 2'd2,
    ST_ABORT = 2'd3
  } state_e;

  // Ops with zero or several bits set are accepted but do nothing.
  function automatic logic op_single(input logic [5:0] op);
    return $onehot(op);
  endfunction

endpackage

// File: rtl/muldiv_hilo_ctrl_hilo_regfile.sv
// Architectural HI/LO registers with write enables and read path.
// Define HILO_FWD_EN to forward the value being written onto the read ports.
module hilo_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic        hi_we,
  input  logic [31:0] hi_wdata,
  input  logic        lo_we,
  input  logic [31:0] lo_wdata,
  output logic [31:0] hi_rdata,
  output logic [31:0] lo_rdata
);

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  always_comb begin
    hi_d = hi_we ? hi_wdata : hi_q;
    lo_d = lo_we ? lo_wdata : lo_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

`ifdef HILO_FWD_EN
  assign hi_rdata = hi_d;
  assign lo_rdata = lo_d;
`else
  assign hi_rdata = hi_q;
  assign lo_rdata = lo_q;
`endif

endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// Sequences the shared multiplier and iterative divider for EXE and owns HI/LO.
// Optional HILO_FWD_EN (in hilo_regfile) forwards HI/LO writes to the read ports.
module muldiv_hilo_ctrl
  import muldiv_pkg::*;
#(
  parameter int MUL_LAT     = MUL_LAT_DEF,
  parameter int DIV_TIMEOUT = DIV_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] hi_rdata,
  output logic [31:0] lo_rdata,
  output logic        mul_signed,
  output logic [31:0] mul_x,
  output logic [31:0] mul_y,
  input  logic [63:0] mul_res,
  output logic        div_req,
  output logic        div_signed,
  output logic [31:0] div_x,
  output logic [31:0] div_y,
  input  logic [31:0] div_s,
  input  logic [31:0] div_r,
  input  logic        div_complete,
  output logic        div_cancel
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        src1_q, src1_d, src2_q, src2_d;
  logic               signed_q, signed_d;
  logic               err_q, err_d;
  logic               dz_done_q, dz_done_d;

  logic accept, single, is_mul, is_div, div_zero, mul_last, div_last;
  logic mul_fin, div_fin, hi_we, lo_we;
  logic [31:0] hi_wdata, lo_wdata;

  assign accept   = req_valid & req_ready & ~flush;
  assign single   = op_single(req_op);
  assign is_mul   = single & (req_op[OP_MULT] | req_op[OP_MULTU]);
  assign is_div   = single & (req_op[OP_DIV] | req_op[OP_DIVU]);
  assign div_zero = (req_src2 == '0);
  assign mul_last = (cnt_q == CNT_W'(MUL_LAT - 1));
  assign div_last = (cnt_q == CNT_W'(DIV_TIMEOUT));

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept & is_mul)                 state_d = ST_MUL;
        else if (accept & is_div & ~div_zero) state_d = ST_DIV;
      end
      ST_MUL:   if (flush | mul_last) state_d = ST_IDLE;
      ST_DIV: begin
        if (flush)             state_d = ST_ABORT;
        else if (div_complete) state_d = ST_IDLE;
        else if (div_last)     state_d = ST_ABORT;
      end
      ST_ABORT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Flush outranks any same-cycle completion: no write, no done.
  always_comb begin
    busy       = (state_q != ST_IDLE);
    req_ready  = ~busy;
    div_req    = (state_q == ST_DIV);
    div_cancel = (state_q == ST_ABORT);
    mul_fin    = (state_q == ST_MUL) & mul_last & ~flush;
    div_fin    = (state_q == ST_DIV) & div_complete & ~flush;
    done       = mul_fin | div_fin | dz_done_q;
    hi_we      = mul_fin | div_fin | (accept & single & req_op[OP_MTHI]);
    lo_we      = mul_fin | div_fin | (accept & single & req_op[OP_MTLO]);
    hi_wdata   = mul_fin ? mul_res[63:32] : (div_fin ? div_r : req_src1);
    lo_wdata   = mul_fin ? mul_res[31:0]  : (div_fin ? div_s : req_src1);
  end

  always_comb begin
    src1_d    = accept ? req_src1 : src1_q;
    src2_d    = accept ? req_src2 : src2_q;
    signed_d  = accept ? (req_op[OP_MULT] | req_op[OP_DIV]) : signed_q;
    cnt_d     = ((state_q == ST_MUL || state_q == ST_DIV) && state_d == state_q)
                ? cnt_q + 1'b1 : '0;
    err_d     = err_q | ((state_q == ST_DIV) & ~flush & ~div_complete & div_last);
    dz_done_d = accept & is_div & div_zero;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      src1_q    <= '0;
      src2_q    <= '0;
      signed_q  <= 1'b0;
      err_q     <= 1'b0;
      dz_done_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      src1_q    <= src1_d;
      src2_q    <= src2_d;
      signed_q  <= signed_d;
      err_q     <= err_d;
      dz_done_q <= dz_done_d;
    end
  end

  assign err        = err_q;
  assign mul_signed = signed_q;
  assign mul_x      = src1_q;
  assign mul_y      = src2_q;
  assign div_signed = signed_q;
  assign div_x      = src1_q;
  assign div_y      = src2_q;

  hilo_regfile u_hilo (
    .clk      (clk),
    .reset    (reset),
    .hi_we    (hi_we),
    .hi_wdata (hi_wdata),
    .lo_we    (lo_we),
    .lo_wdata (lo_wdata),
    .hi_rdata (hi_rdata),
    .lo_rdata (lo_rdata)
  );

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Self-checking bench for muldiv_hilo_ctrl: transaction-level HI/LO model,
// per-cycle compare process, and literal spot checks.
module tb_muldiv_hilo_ctrl;

  localparam int MUL_LAT     = 2;
  localparam int DIV_TIMEOUT = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, flush, busy, done, err;
  logic [5:0]  req_op;
  logic [31:0] req_src1, req_src2, hi_rdata, lo_rdata;
  logic        mul_signed, div_req, div_signed, div_complete, div_cancel;
  logic [31:0] mul_x, mul_y, div_x, div_y, div_s, div_r;
  logic [63:0] mul_res;

  always #5 clk = ~clk;

  muldiv_hilo_ctrl #(.MUL_LAT(MUL_LAT), .DIV_TIMEOUT(DIV_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_src1(req_src1), .req_src2(req_src2), .flush(flush),
    .busy(busy), .done(done), .err(err), .hi_rdata(hi_rdata), .lo_rdata(lo_rdata),
    .mul_signed(mul_signed), .mul_x(mul_x), .mul_y(mul_y), .mul_res(mul_res),
    .div_req(div_req), .div_signed(div_signed), .div_x(div_x), .div_y(div_y),
    .div_s(div_s), .div_r(div_r), .div_complete(div_complete), .div_cancel(div_cancel)
  );

  // Multiplier model: product of the applied operands, one register stage
  // so the result is valid MUL_LAT (=2) cycles after operands appear.
  logic signed [63:0] ms_x, ms_y;
  logic [63:0] prod_now, prod_q;
  always_comb begin
    ms_x = {{32{mul_x[31]}}, mul_x};
    ms_y = {{32{mul_y[31]}}, mul_y};
    prod_now = mul_signed ? 64'(ms_x * ms_y) : {32'b0, mul_x} * {32'b0, mul_y};
  end
  always @(posedge clk) prod_q <= prod_now;
  assign mul_res = prod_q;

  int n_pass = 0;
  int n_chk  = 0;
  logic chk_en = 1'b0;

  // Architectural model and per-cycle expectations.
  logic [31:0] m_hi, m_lo, w_hi, w_lo, e_divx, e_divy;
  logic        w_hi_en, w_lo_en, e_busy, e_done, e_err, e_divreq, e_cancel, e_dsgn;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] view_hi();
`ifdef HILO_FWD_EN
    return w_hi_en ? w_hi : m_hi;
`else
    return m_hi;
`endif
  endfunction

  function automatic logic [31:0] view_lo();
`ifdef HILO_FWD_EN
    return w_lo_en ? w_lo : m_lo;
`else
    return m_lo;
`endif
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",       32'(busy),       32'(e_busy));
      check("req_ready",  32'(req_ready),  32'(!e_busy));
      check("done",       32'(done),       32'(e_done));
      check("err",        32'(err),        32'(e_err));
      check("div_req",    32'(div_req),    32'(e_divreq));
      check("div_cancel", 32'(div_cancel), 32'(e_cancel));
      check("hi_rdata",   hi_rdata,        view_hi());
      check("lo_rdata",   lo_rdata,        view_lo());
      if (e_divreq) begin
        check("div_x",      div_x,             e_divx);
        check("div_y",      div_y,             e_divy);
        check("div_signed", 32'(div_signed),   32'(e_dsgn));
      end
    end
  end

  // Advance one cycle; commit pending HI/LO writes and return to idle defaults.
  task automatic tick();
    @(posedge clk);
    #1;
    if (w_hi_en) m_hi = w_hi;
    if (w_lo_en) m_lo = w_lo;
    w_hi_en = 1'b0; w_lo_en = 1'b0;
    req_valid = 1'b0; flush = 1'b0; div_complete = 1'b0;
    e_busy = 1'b0; e_done = 1'b0; e_divreq = 1'b0; e_cancel = 1'b0;
  endtask

  task automatic do_mul(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input int flush_at);
    logic signed [63:0] sa, sb;
    logic [63:0] p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    p  = sgn ? 64'(sa * sb) : {32'b0, a} * {32'b0, b};
    req_valid = 1'b1; req_op = sgn ? 6'b000001 : 6'b000010;
    req_src1 = a; req_src2 = b;
    tick();
    for (int i = 1; i <= MUL_LAT; i++) begin
      e_busy = 1'b1;
      if (i == flush_at) begin
        flush = 1'b1;
        tick();
        return;
      end
      if (i == MUL_LAT) begin
        e_done = 1'b1; w_hi_en = 1'b1; w_lo_en = 1'b1;
        w_hi = p[63:32]; w_lo = p[31:0];
      end
      tick();
    end
  endtask

  task automatic do_mt(input logic to_hi, input logic [31:0] v, input logic fl);
    req_valid = 1'b1; req_op = to_hi ? 6'b010000 : 6'b100000;
    req_src1 = v; req_src2 = 32'hDEAD_BEEF; flush = fl;
    if (!fl) begin
      if (to_hi) begin w_hi_en = 1'b1; w_hi = v; end
      else       begin w_lo_en = 1'b1; w_lo = v; end
    end
    tick();
  endtask

  // lat/flush_at: DIV-state cycle index of div_complete / flush (-1 = never).
  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input int flush_at);
    logic [31:0] q, r;
    req_valid = 1'b1; req_op = sgn ? 6'b000100 : 6'b001000;
    req_src1 = a; req_src2 = b;
    tick();
    if (b == 32'd0) begin
      e_done = 1'b1;
      tick();
      return;
    end
    q = sgn ? 32'($signed(a) / $signed(b)) : a / b;
    r = sgn ? 32'($signed(a) % $signed(b)) : a % b;
    for (int i = 0; i <= DIV_TIMEOUT; i++) begin
      e_busy = 1'b1; e_divreq = 1'b1; e_divx = a; e_divy = b; e_dsgn = sgn;
      if (i == lat) begin
        div_complete = 1'b1; div_s = q; div_r = r;
      end
      if (i == flush_at) begin
        flush = 1'b1;
        tick();
        break;
      end
      if (i == lat) begin
        e_done = 1'b1; w_hi_en = 1'b1; w_lo_en = 1'b1; w_hi = r; w_lo = q;
        tick();
        return;
      end
      tick();
      if (i == DIV_TIMEOUT) e_err = 1'b1;
    end
    e_busy = 1'b1; e_cancel = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_src1 = '0; req_src2 = '0;
    flush = 1'b0; div_s = '0; div_r = '0; div_complete = 1'b0;
    m_hi = '0; m_lo = '0; w_hi = '0; w_lo = '0; w_hi_en = 1'b0; w_lo_en = 1'b0;
    e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0; e_divreq = 1'b0; e_cancel = 1'b0;
    e_divx = '0; e_divy = '0; e_dsgn = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_hi", hi_rdata, 32'h0);
    check("rst_lo", lo_rdata, 32'h0);
    check("rst_ready", 32'(req_ready), 32'h1);
    tick();

    do_mul(1'b1, 32'hFFFF_FFFF, 32'h0000_0002, -1);
    check("mult_hi", hi_rdata, 32'hFFFF_FFFF);
    check("mult_lo", lo_rdata, 32'hFFFF_FFFE);
    do_mul(1'b0, 32'hFFFF_FFFF, 32'h0000_0002, -1);
    check("multu_hi", hi_rdata, 32'h0000_0001);
    check("multu_lo", lo_rdata, 32'hFFFF_FFFE);
    tick();
    do_mul(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, -1);

    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 33, -1);
    check("div_lo", lo_rdata, 32'hFFFF_FFFD);
    check("div_hi", hi_rdata, 32'hFFFF_FFFF);
    tick();
    do_div(1'b0, 32'd100, 32'd7, 5, -1);
    check("divu_lo", lo_rdata, 32'd14);
    check("divu_hi", hi_rdata, 32'd2);
    do_div(1'b0, 32'd55, 32'd0, -1, -1);
    check("dz_lo", lo_rdata, 32'd14);

    do_mt(1'b1, 32'h11, 1'b0);
    do_mt(1'b0, 32'h22, 1'b0);
    do_div(1'b1, 32'd100, 32'd7, -1, 10);
    tick();
    check("flush_hi", hi_rdata, 32'h11);
    check("flush_lo", lo_rdata, 32'h22);

    do_mt(1'b1, 32'hABCD, 1'b1);
    check("mt_flush_hi", hi_rdata, 32'h11);
    req_valid = 1'b1; req_op = 6'b000011; req_src1 = 32'h7; req_src2 = 32'h9;
    tick();
    tick();
    do_mul(1'b1, 32'd3, 32'd4, 1);
    do_mul(1'b1, 32'd3, 32'd4, MUL_LAT);
    do_div(1'b0, 32'd50, 32'd5, 3, 3);
    check("mul_div_flush_lo", lo_rdata, 32'h22);
    tick();

    do_div(1'b1, 32'd9, 32'd3, -1, -1);
    check("timeout_err", 32'(err), 32'h1);
    do_mt(1'b0, 32'h5, 1'b0);
    check("mtlo_after_err", lo_rdata, 32'h5);
    tick();
    tick();

    // Reset in the middle of a divide: no cancel pulse, everything cleared.
    req_valid = 1'b1; req_op = 6'b001000; req_src1 = 32'd77; req_src2 = 32'd3;
    tick();
    repeat (3) begin
      e_busy = 1'b1; e_divreq = 1'b1; e_divx = 32'd77; e_divy = 32'd3; e_dsgn = 1'b0;
      tick();
    end
    e_busy = 1'b1; e_divreq = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0; m_hi = '0; m_lo = '0; e_err = 1'b0;
    tick();
    check("rst_mid_err", 32'(err), 32'h0);
    check("rst_mid_lo", lo_rdata, 32'h0);
    tick();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
